// File: rtl/d05200_otp_pkg.sv
// Shared types and default timing for the d05200 OTP macro sequencers (program and read paths).
package d05200_otp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHKEN,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_VERIFY,
    S_CHECK,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_LOCK  = 2'b01,
    ST_VFAIL = 2'b10,
    ST_ABORT = 2'b11
  } status_e;

  localparam int unsigned DEF_SETUP_CYC = 4;
  localparam int unsigned DEF_PULSE_CYC = 200;
  localparam int unsigned DEF_HOLD_CYC  = 4;
  localparam int unsigned DEF_READ_CYC  = 3;
  localparam int unsigned DEF_MAX_RETRY = 3;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Counter is loaded with (cycles - 1), so clog2(max) bits always suffice.
  function automatic int unsigned tmr_width(input int unsigned max_cyc);
    return (max_cyc > 2) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/d05200_otp_prog_if.sv
// Command-side request/response and OTP macro pins of the program sequencer.
interface d05200_otp_prog_if;
  logic       PROG_EN;
  logic       ABORT;
  logic       REQ;
  logic [6:0] ADDR;
  logic [7:0] DATA;
  logic       BUSY;
  logic       DONE;
  logic [1:0] STATUS;
  logic [7:0] RDATA;
  logic       OTP_CS;
  logic       OTP_READ;
  logic       OTP_PROG;
  logic [6:0] OTP_ADDR;
  logic [7:0] OTP_DATI;
  logic [7:0] OTP_DATO;

  modport master (
    output PROG_EN, ABORT, REQ, ADDR, DATA, OTP_DATO,
    input  BUSY, DONE, STATUS, RDATA, OTP_CS, OTP_READ, OTP_PROG, OTP_ADDR, OTP_DATI
  );

  modport slave (
    input  PROG_EN, ABORT, REQ, ADDR, DATA, OTP_DATO,
    output BUSY, DONE, STATUS, RDATA, OTP_CS, OTP_READ, OTP_PROG, OTP_ADDR, OTP_DATI
  );
endinterface

// File: rtl/d05200_otp_tmr.sv
// Loadable down-counter that stops at zero; shared by the OTP program and read sequencers.
module d05200_otp_tmr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  assign zero = (cnt_q == '0);

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (!zero) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/d05200_otp_prog.sv
// OTP byte-program sequencer: setup, PROG pulse, hold, read-back verify with bounded retry.
// Optional macro D05200_OTP_VERIFY_EN enables the VERIFY/CHECK/retry flow.
module d05200_otp_prog
  import d05200_otp_pkg::*;
#(
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
  parameter int unsigned READ_CYC  = DEF_READ_CYC,
  parameter int unsigned MAX_RETRY = DEF_MAX_RETRY
) (
  input logic              HCLK,
  input logic              RESET,
  d05200_otp_prog_if.slave bus
);

  localparam int unsigned MAX_CYC = max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, READ_CYC);
  localparam int unsigned TW      = tmr_width(MAX_CYC);

  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] READ_LD  = TW'(READ_CYC - 1);

  state_e        state_d, state_q;
  status_e       status_d, status_q;
  logic [7:0]    rdata_d, rdata_q;
  logic [6:0]    addr_d, addr_q;
  logic [7:0]    data_d, data_q;
  logic          abort_d, abort_q;
  logic          tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic          busy;

`ifdef D05200_OTP_VERIFY_EN
  logic [2:0]    retry_d, retry_q;
`else
  logic          unused_sink;
  assign unused_sink = ^{bus.OTP_DATO, 3'(MAX_RETRY)};
`endif

  d05200_otp_tmr #(.W(TW)) u_tmr (
    .clk      (HCLK),
    .rst_n    (RESET),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // State register and captured request/result.
  always_ff @(posedge HCLK) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      rdata_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      abort_q  <= 1'b0;
`ifdef D05200_OTP_VERIFY_EN
      retry_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      abort_q  <= abort_d;
`ifdef D05200_OTP_VERIFY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  // Next state; ABORT during PULSE is deferred so the pulse is followed by a full HOLD.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    data_d   = data_q;
    abort_d  = abort_q;
`ifdef D05200_OTP_VERIFY_EN
    retry_d  = retry_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.REQ) begin
          state_d  = S_CHKEN;
          addr_d   = bus.ADDR;
          data_d   = bus.DATA;
          abort_d  = 1'b0;
          status_d = ST_OK;
          rdata_d  = '0;
`ifdef D05200_OTP_VERIFY_EN
          retry_d  = '0;
`endif
        end
      end
      S_CHKEN: begin
        if (!bus.PROG_EN) begin
          state_d  = S_DONE;
          status_d = ST_LOCK;
        end else begin
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (bus.ABORT) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (tmr_zero) begin
          state_d  = S_PULSE;
        end
      end
      S_PULSE: begin
        if (bus.ABORT) begin
          state_d = S_HOLD;
          abort_d = 1'b1;
        end else if (tmr_zero) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        abort_d = abort_q | bus.ABORT;
        if (tmr_zero) begin
          if (abort_d) begin
            state_d  = S_DONE;
            status_d = ST_ABORT;
          end else begin
`ifdef D05200_OTP_VERIFY_EN
            state_d  = S_VERIFY;
`else
            state_d  = S_DONE;
            status_d = ST_OK;
`endif
          end
        end
      end
`ifdef D05200_OTP_VERIFY_EN
      S_VERIFY: begin
        if (bus.ABORT) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (tmr_zero) begin
          state_d = S_CHECK;
          rdata_d = bus.OTP_DATO;
        end
      end
      S_CHECK: begin
        // A bit set that should be clear can never be undone by another pulse.
        if (rdata_q == data_q) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end else if ((rdata_q & ~data_q) != '0) begin
          state_d  = S_DONE;
          status_d = ST_VFAIL;
        end else if (retry_q < 3'(MAX_RETRY)) begin
          state_d  = S_PULSE;
          retry_d  = retry_q + 1'b1;
        end else begin
          state_d  = S_DONE;
          status_d = ST_VFAIL;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The shared timer is reloaded with the duration of whichever state is being entered.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      S_SETUP:  tmr_val = SETUP_LD;
      S_PULSE:  tmr_val = PULSE_LD;
      S_HOLD:   tmr_val = HOLD_LD;
      S_VERIFY: tmr_val = READ_LD;
      default:  tmr_val = '0;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    busy         = (state_q != S_IDLE);
    bus.BUSY     = busy;
    bus.DONE     = (state_q == S_DONE);
    bus.STATUS   = status_q;
    bus.RDATA    = rdata_q;
    bus.OTP_CS   = state_q inside {S_SETUP, S_PULSE, S_HOLD, S_VERIFY, S_CHECK};
    bus.OTP_PROG = (state_q == S_PULSE);
`ifdef D05200_OTP_VERIFY_EN
    bus.OTP_READ = (state_q == S_VERIFY);
`else
    bus.OTP_READ = 1'b0;
`endif
    bus.OTP_ADDR = busy ? addr_q : '0;
    bus.OTP_DATI = busy ? data_q : '0;
  end

endmodule

// File: doc/d05200_otp_prog.md
# d05200_otp_prog

OTP program sequencer: the write-side counterpart of the OTP read path in `d05200_dc_top`. It takes one byte-program request (address + data) from the OWL command layer and drives the 128x8 OTP macro through setup, PROG pulse, hold and read-back verify, with bounded retry. It sits between the command decoder and the OTP pins, and is muxed with the read path by `OTP_CS` ownership (BUSY=1 means this block owns the macro).

## Interface
- `SETUP_CYC`, default 4: cycles of CS/ADR/DIN stable before PROG.
- `PULSE_CYC`, default 200: cycles of PROG high per pulse.
- `HOLD_CYC`, default 4: cycles after PROG falls before READ.
- `READ_CYC`, default 3: cycles of READ high; DO is sampled on the last one.
- `MAX_RETRY`, default 3: extra pulses allowed after a failed verify (0..7).
- `HCLK`  in  1  system clock.
- `RESET`  in  1  synchronous, active-low reset.
- `PROG_EN`  in  1  programming unlock, sampled at accept.
- `ABORT`  in  1  abort the current operation.
- `REQ`  in  1  program request.
- `ADDR`  in  7  target byte address.
- `DATA`  in  8  target byte value.
- `BUSY`  out  1  operation in progress.
- `DONE`  out  1  one-cycle completion pulse.
- `STATUS`  out  2  result, valid with DONE: 00 ok, 01 locked, 10 verify fail, 11 aborted.
- `RDATA`  out  8  last read-back byte.
- `OTP_CS`, `OTP_READ`, `OTP_PROG`  out  1  macro controls.
- `OTP_ADDR`  out  7  macro address.
- `OTP_DATI`  out  8  macro write data.
- `OTP_DATO`  in  8  macro read data.

## Operation
- Reset (RESET=0 at a HCLK edge) puts every output at 0 and the FSM in IDLE. This holds mid-pulse too: PROG falls on that same edge.
- Accept: `REQ=1 & BUSY=0` in IDLE. ADDR and DATA are captured, and the retry count is cleared. REQ while BUSY is ignored, with no queueing.
- States:
  - IDLE to CHKEN on accept.
  - CHKEN: PROG_EN=0 goes to DONE with STATUS 01 and no OTP activity. Otherwise go to SETUP.
  - SETUP: CS=1, ADR and DIN driven, for SETUP_CYC cycles.
  - PULSE: CS=1, PROG=1, for PULSE_CYC cycles.
  - HOLD: CS=1, PROG=0, for HOLD_CYC cycles.
  - VERIFY: CS=1, READ=1, for READ_CYC cycles. DO is latched to RDATA on the last cycle.
  - CHECK: one cycle with CS=1.
    - RDATA==DATA goes to DONE with STATUS 00.
    - If `(RDATA & ~DATA)!=0` (over-programmed, unrecoverable), go to DONE with STATUS 10 immediately.
    - Otherwise, retry<MAX_RETRY increments retry and goes to PULSE.
    - Otherwise go to DONE with STATUS 10.
  - DONE: DONE=1, BUSY=1, CS=0, STATUS valid. Next state is IDLE.
- ABORT:
  - In SETUP or VERIFY, go to DONE with STATUS 11.
  - In PULSE, PROG drops on the next edge and the FSM goes to HOLD, then to DONE with STATUS 11 once HOLD completes. The pulse is never truncated to a glitch shorter than one cycle.
  - ABORT is ignored in IDLE, CHKEN, CHECK and DONE.
- STATUS and RDATA hold their values until the next accept.
- OTP_ADDR and OTP_DATI hold the captured values while BUSY=1 and are 0 in IDLE.
- Only one of PROG or READ is ever high.

## Timing
- Accept at edge N. BUSY=1 from N+1 until DONE completes; BUSY=0 in the cycle after DONE.
- Locked case: CHKEN at N+1, DONE at N+2, BUSY=0 at N+3.
- Pass on first try: DONE in cycle N+2+SETUP_CYC+PULSE_CYC+HOLD_CYC+READ_CYC+1.
- Each retry adds PULSE_CYC+HOLD_CYC+READ_CYC+1 cycles.
- The cycle counter is one shared down-counter. Its width is clog2 of the largest timing parameter. It is reloaded on each state entry.
- REQ may be asserted in the DONE cycle; it is accepted only once BUSY=0.

## Configuration
- `D05200_OTP_VERIFY_EN` defined: full VERIFY/CHECK/retry flow as above.
- Not defined:
  - After HOLD the FSM goes directly to DONE with STATUS 00.
  - VERIFY and CHECK are removed and MAX_RETRY is unused.
  - RDATA is held at 0 and READ never asserts.
  - Latency is N+2+SETUP_CYC+PULSE_CYC+HOLD_CYC.

## Structure
- Package `d05200_otp_pkg` holds:
  - the state enum;
  - the STATUS codes (ST_OK, ST_LOCK, ST_VFAIL, ST_ABORT);
  - the default timing constants, shared with the read path.
- Sub-module `d05200_otp_tmr` is the loadable down-counter with a `zero` flag, reused by the read path.

## Test plan
- **Locked:** PROG_EN=0, REQ with ADDR=0x05, DATA=0xA5.
  - DONE at N+2 with STATUS=01.
  - OTP_CS, OTP_PROG and OTP_READ stay 0 throughout.
- **Clean program:** PROG_EN=1, ADDR=0x7F, DATA=0x3C, model returns 0x3C.
  - Exactly one PROG pulse of PULSE_CYC cycles.
  - DONE with STATUS=00 and RDATA=0x3C at the computed cycle.
- **Retry exhaustion:** model returns 0x38 for DATA=0x3C.
  - MAX_RETRY+1=4 pulses, then STATUS=10 and RDATA=0x38.
  - Also check: model returns 0x3C on the 2nd read, giving 2 pulses and STATUS=00.
- **Over-programmed:** model returns 0x3D for DATA=0x3C.
  - One pulse, then STATUS=10 with no retry.
- **Abort mid-pulse:** ABORT at pulse cycle 50.
  - PROG falls on the next edge.
  - HOLD_CYC cycles follow, then DONE with STATUS=11.
- **Reset mid-pulse:** RESET=0 during PULSE.
  - All outputs are 0 on that edge.
  - REQ during BUSY in a separate run is ignored (exactly one DONE).
